// File: rtl/peripheral_operand_collector.sv
// peripheral_operand_collector: assembles NUM_OPS operands of OP_W bits from hand-entered
// DATA_W-bit words, committed one per rising edge of the debounced enter button.
module peripheral_operand_collector #(
  parameter int DATA_W = 8,
  parameter int OP_W = 32,
  parameter int NUM_OPS = 2,
  parameter int LSB_FIRST = 1,
  localparam int WPO = OP_W / DATA_W,
  localparam int WI_W = $clog2(WPO) + 1,
  localparam int OI_W = $clog2(NUM_OPS) + 1,
  localparam int BW = $clog2(NUM_OPS * OP_W)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         inputdata,
  input  logic                      enter,
  input  logic                      clear,
  input  logic                      ack,
  output logic [NUM_OPS*OP_W-1:0]   operands,
  output logic                      op_valid,
  output logic [WI_W-1:0]           word_idx,
  output logic [OI_W-1:0]           op_idx,
  output logic                      overrun
);
  typedef enum logic {COLLECT, FULL} state_t;
  state_t r_state, w_state_n;
  logic [NUM_OPS*OP_W-1:0] r_ops, w_ops_n;
  logic r_valid, w_valid_n, r_ovr, w_ovr_n, r_enter_q, w_edge;
  logic [WI_W-1:0] r_wi, w_wi_n, w_slot;
  logic [OI_W-1:0] r_oi, w_oi_n;
  logic [BW-1:0] w_base;
  assign w_edge = enter & ~r_enter_q;
  assign w_slot = (LSB_FIRST != 0) ? r_wi : WI_W'(WPO - 1) - r_wi;
  assign w_base = BW'(32'(r_oi) * OP_W + 32'(w_slot) * DATA_W);
  // clear outranks ack, and ack outranks a same-cycle button edge
  always_comb begin
    w_state_n = r_state;
    w_ops_n = r_ops;
    w_valid_n = r_valid;
    w_wi_n = r_wi;
    w_oi_n = r_oi;
    w_ovr_n = r_ovr;
    if (clear) begin
      w_state_n = COLLECT;
      w_ops_n = '0;
      w_valid_n = 1'b0;
      w_wi_n = '0;
      w_oi_n = '0;
      w_ovr_n = 1'b0;
    end else if (r_state == FULL) begin
      if (ack) begin
        w_state_n = COLLECT;
        w_valid_n = 1'b0;
        w_wi_n = '0;
        w_oi_n = '0;
      end else if (w_edge) w_ovr_n = 1'b1;
    end else if (w_edge) begin
      w_ops_n[w_base +: DATA_W] = inputdata;
      w_wi_n = (r_wi == WI_W'(WPO - 1)) ? '0 : r_wi + 1'b1;
      if (r_wi == WI_W'(WPO - 1)) begin
        w_oi_n = (r_oi == OI_W'(NUM_OPS - 1)) ? '0 : r_oi + 1'b1;
        w_state_n = (r_oi == OI_W'(NUM_OPS - 1)) ? FULL : COLLECT;
        w_valid_n = (r_oi == OI_W'(NUM_OPS - 1));
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= COLLECT;
      r_ops <= '0;
      r_valid <= 1'b0;
      r_wi <= '0;
      r_oi <= '0;
      r_ovr <= 1'b0;
      r_enter_q <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_ops <= w_ops_n;
      r_valid <= w_valid_n;
      r_wi <= w_wi_n;
      r_oi <= w_oi_n;
      r_ovr <= w_ovr_n;
      r_enter_q <= enter;
    end
  end
  assign operands = r_ops;
  assign op_valid = r_valid;
  assign word_idx = r_wi;
  assign op_idx = r_oi;
  assign overrun = r_ovr;
endmodule

// File: tb/tb_peripheral_operand_collector.sv
// tb_peripheral_operand_collector: scoreboard bench over three parameterisations
// (LSB-first default, MSB-first, three 16-bit operands) sharing one stimulus stream.
module tb_peripheral_operand_collector;
  logic clk = 1'b0, reset, enter, clear, ack;
  logic [7:0] inputdata;
  logic [63:0] l_ops, m_ops;
  logic [47:0] s_ops;
  logic l_valid, m_valid, s_valid, l_ovr, m_ovr, s_ovr;
  logic [2:0] l_wi, m_wi, s_oi;
  logic [1:0] l_oi, m_oi, s_wi;
  int checks = 0, failures = 0;
  logic [63:0] q_l[$], q_m[$];
  logic [47:0] q_s[$];

  always #5 clk = ~clk;

  peripheral_operand_collector u_lsb (.clk(clk), .reset(reset), .inputdata(inputdata), .enter(enter),
    .clear(clear), .ack(ack), .operands(l_ops), .op_valid(l_valid), .word_idx(l_wi), .op_idx(l_oi),
    .overrun(l_ovr));
  peripheral_operand_collector #(.LSB_FIRST(0)) u_msb (.clk(clk), .reset(reset), .inputdata(inputdata),
    .enter(enter), .clear(clear), .ack(ack), .operands(m_ops), .op_valid(m_valid), .word_idx(m_wi),
    .op_idx(m_oi), .overrun(m_ovr));
  peripheral_operand_collector #(.OP_W(16), .NUM_OPS(3)) u_small (.clk(clk), .reset(reset),
    .inputdata(inputdata), .enter(enter), .clear(clear), .ack(ack), .operands(s_ops), .op_valid(s_valid),
    .word_idx(s_wi), .op_idx(s_oi), .overrun(s_ovr));

  task automatic press(input logic [7:0] d);
    @(negedge clk);
    inputdata = d;
    enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
  endtask

  task automatic pop_l(input string nm);
    logic [63:0] e;
    int n = 0;
    while (l_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (l_valid !== 1'b1 || q_l.size() == 0) begin
      failures++;
      $display("FAIL %s: op_valid=%b pending=%0d, required valid=1 with a queued result", nm, l_valid, q_l.size());
    end else begin
      e = q_l.pop_front();
      if (l_ops !== e) begin
        failures++;
        $display("FAIL %s: operands=%h required=%h", nm, l_ops, e);
      end
    end
  endtask

  task automatic pop_m(input string nm);
    logic [63:0] e;
    int n = 0;
    while (m_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (m_valid !== 1'b1 || q_m.size() == 0) begin
      failures++;
      $display("FAIL %s: op_valid=%b pending=%0d, required valid=1 with a queued result", nm, m_valid, q_m.size());
    end else begin
      e = q_m.pop_front();
      if (m_ops !== e) begin
        failures++;
        $display("FAIL %s: operands=%h required=%h", nm, m_ops, e);
      end
    end
  endtask

  task automatic pop_s(input string nm);
    logic [47:0] e;
    int n = 0;
    while (s_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (s_valid !== 1'b1 || q_s.size() == 0) begin
      failures++;
      $display("FAIL %s: op_valid=%b pending=%0d, required valid=1 with a queued result", nm, s_valid, q_s.size());
    end else begin
      e = q_s.pop_front();
      if (s_ops !== e) begin
        failures++;
        $display("FAIL %s: operands=%h required=%h", nm, s_ops, e);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    enter = 1'b0;
    clear = 1'b0;
    ack = 1'b0;
    inputdata = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({l_ops, l_valid, l_wi, l_oi, l_ovr} !== '0) begin
      failures++;
      $display("FAIL reset_lsb: state=%h required=0", {l_ops, l_valid, l_wi, l_oi, l_ovr});
    end
    checks++;
    if ({s_ops, s_valid, s_wi, s_oi, s_ovr} !== '0) begin
      failures++;
      $display("FAIL reset_small: state=%h required=0", {s_ops, s_valid, s_wi, s_oi, s_ovr});
    end
  endtask

  task automatic test_collect;
    q_l.push_back(64'h88776655_44332211);
    q_m.push_back(64'h55667788_11223344);
    for (int i = 1; i <= 7; i++) press(8'(8'h11 * i));
    checks++;
    if (l_valid !== 1'b0 || l_wi !== 3'd3 || l_oi !== 2'd1) begin
      failures++;
      $display("FAIL collect_7words: valid=%b wi=%0d oi=%0d required valid=0 wi=3 oi=1", l_valid, l_wi, l_oi);
    end
    press(8'h88);
    checks++;
    if (l_valid !== 1'b1 || m_valid !== 1'b1) begin
      failures++;
      $display("FAIL valid_latency: lsb=%b msb=%b required 1 one cycle after last edge", l_valid, m_valid);
    end
    pop_l("collect_lsb");
    pop_m("collect_msb");
    checks++;
    if (l_wi !== 3'd0 || l_oi !== 2'd0) begin
      failures++;
      $display("FAIL wrap_idx: wi=%0d oi=%0d required 0 0", l_wi, l_oi);
    end
  endtask

  task automatic test_overrun;
    press(8'hFF);
    checks++;
    if (l_ovr !== 1'b1 || l_valid !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set: ovr=%b valid=%b required 1 1", l_ovr, l_valid);
    end
    checks++;
    if (l_ops !== 64'h88776655_44332211) begin
      failures++;
      $display("FAIL overrun_hold: operands=%h required=8877665544332211", l_ops);
    end
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checks++;
    if (l_valid !== 1'b0 || l_wi !== 3'd0 || l_oi !== 2'd0 || l_ovr !== 1'b1) begin
      failures++;
      $display("FAIL ack: valid=%b wi=%0d oi=%0d ovr=%b required 0 0 0 1", l_valid, l_wi, l_oi, l_ovr);
    end
    checks++;
    if (l_ops !== 64'h88776655_44332211) begin
      failures++;
      $display("FAIL ack_keep: operands=%h required=8877665544332211", l_ops);
    end
  endtask

  task automatic test_hold;
    @(negedge clk);
    inputdata = 8'hAA;
    enter = 1'b1;
    repeat (20) @(negedge clk);
    enter = 1'b0;
    @(negedge clk);
    checks++;
    if (l_wi !== 3'd1 || m_wi !== 3'd1) begin
      failures++;
      $display("FAIL held_enter_idx: lsb_wi=%0d msb_wi=%0d required 1 1", l_wi, m_wi);
    end
    checks++;
    if (l_ops !== 64'h88776655_443322AA) begin
      failures++;
      $display("FAIL held_enter_data: operands=%h required=88776655443322aa", l_ops);
    end
  endtask

  task automatic test_clear;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if (l_ovr !== 1'b0 || l_ops !== 64'h0 || l_wi !== 3'd0) begin
      failures++;
      $display("FAIL clear: ovr=%b ops=%h wi=%0d required 0 0 0", l_ovr, l_ops, l_wi);
    end
    for (int i = 1; i <= 5; i++) press(8'(i));
    checks++;
    if (l_ops !== 64'h00000005_04030201 || l_wi !== 3'd1 || l_oi !== 2'd1) begin
      failures++;
      $display("FAIL five_words: ops=%h wi=%0d oi=%0d required 0000000504030201 1 1", l_ops, l_wi, l_oi);
    end
    @(negedge clk);
    clear = 1'b1;
    enter = 1'b1;
    inputdata = 8'hEE;
    @(negedge clk);
    clear = 1'b0;
    enter = 1'b0;
    checks++;
    if ({l_ops, l_valid, l_wi, l_oi, l_ovr} !== '0) begin
      failures++;
      $display("FAIL clear_vs_edge: state=%h required=0", {l_ops, l_valid, l_wi, l_oi, l_ovr});
    end
    q_l.push_back(64'h28272625_24232221);
    for (int i = 1; i <= 8; i++) press(8'(8'h20 + i));
    pop_l("refill_after_clear");
    @(negedge clk);
    ack = 1'b1;
    enter = 1'b1;
    inputdata = 8'h99;
    @(negedge clk);
    ack = 1'b0;
    enter = 1'b0;
    checks++;
    if (l_valid !== 1'b0 || l_ovr !== 1'b0 || l_wi !== 3'd0 || l_ops !== 64'h28272625_24232221) begin
      failures++;
      $display("FAIL ack_vs_edge: valid=%b ovr=%b wi=%0d ops=%h required 0 0 0 2827262524232221",
               l_valid, l_ovr, l_wi, l_ops);
    end
  endtask

  task automatic test_async_reset;
    for (int i = 1; i <= 3; i++) press(8'(8'h30 + i));
    checks++;
    if (l_wi !== 3'd3) begin
      failures++;
      $display("FAIL pre_reset_idx: wi=%0d required 3", l_wi);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({l_ops, l_valid, l_wi, l_oi, l_ovr} !== '0 || {s_ops, s_valid, s_wi, s_oi, s_ovr} !== '0) begin
      failures++;
      $display("FAIL async_reset: lsb=%h small=%h required 0 before next edge",
               {l_ops, l_valid, l_wi, l_oi, l_ovr}, {s_ops, s_valid, s_wi, s_oi, s_ovr});
    end
    @(negedge clk);
    reset = 1'b0;
    q_s.push_back(48'h6655_4433_2211);
    for (int i = 1; i <= 6; i++) press(8'(8'h11 * i));
    pop_s("three_ops_16b");
    checks++;
    if (s_wi !== 2'd0 || s_oi !== 3'd0) begin
      failures++;
      $display("FAIL small_wrap: wi=%0d oi=%0d required 0 0", s_wi, s_oi);
    end
    checks++;
    if (l_valid !== 1'b0 || l_wi !== 3'd2 || l_oi !== 2'd1) begin
      failures++;
      $display("FAIL lsb_partial: valid=%b wi=%0d oi=%0d required 0 2 1", l_valid, l_wi, l_oi);
    end
  endtask

  initial begin
    test_reset();
    test_collect();
    test_overrun();
    test_hold();
    test_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
